mac_tile: RTL and testbench
===========================

# mac_tile

Weight-stationary processing element that directly wraps the array's `mac` datapath. It latches one signed weight, forwards activations and instructions east, and passes registered partial sums south. Tiles chain west-to-east on the activation/weight bus and north-to-south on the psum bus to form the systolic array. All outputs are registered, so each tile adds exactly one cycle of latency per hop.

## Interface
Parameters:
- `a_bw`, default 2: activation width, treated as unsigned.
- `b_bw`, default 4: weight width, signed two's complement; also the width of the west/east bus.
- `psum_bw`, default 16: partial-sum width, signed.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_w`  in  b_bw  west bus; weight during load, activation in `in_w[a_bw-1:0]` during execute.
- `inst_w`  in  2  instruction; bit0 = kernel load, bit1 = execute.
- `in_n`  in  psum_bw  incoming psum from the north.
- `out_e`  out  b_bw  registered forward of `in_w`.
- `inst_e`  out  2  registered forwarded instruction.
- `out_s`  out  psum_bw  registered psum to the south.

## Operation
- State machine has two states: EMPTY and LOADED.
  - Reset places the tile in EMPTY.
  - EMPTY → LOADED on the first cycle with `inst_w[0]=1`; that cycle captures `in_w` into weight register `b_q`.
  - LOADED is held until `reset`; reloading the kernel requires a reset.
- Forwarding:
  - When `inst_w != 0`, `in_w` is registered to `out_e`; otherwise `out_e` holds.
  - `inst_e[1]` is `inst_w[1]` delayed one cycle, every cycle.
  - `inst_e[0]` is `inst_w[0]` delayed one cycle, but is forced to 0 while the state is EMPTY, including the capture cycle. The first weight therefore stays in this tile and later weights propagate east.
- Execute: when `inst_w[1]=1`, `out_s` is registered with `in_n + zext(in_w[a_bw-1:0]) * b_q`. When `inst_w[1]=0`, `out_s` holds.
- Arithmetic:
  - The activation is zero-extended to a_bw+1 bits; the product is signed, a_bw+b_bw+1 bits.
  - The sum is computed at psum_bw+1 bits and then reduced to psum_bw bits (wrap or saturate; see Configuration).
- Load and execute in the same cycle (`inst_w=11`): execute uses the old `b_q`. In EMPTY, `b_q=0`, so `out_s` becomes `in_n`; the load still captures the weight.
- Reset mid-operation takes priority over every instruction and clears all state in that cycle.

## Timing
- Reset values: `out_e=0`, `inst_e=0`, `out_s=0`, `b_q=0`, state EMPTY.
- Latency: exactly 1 cycle from `in_w`/`inst_w`/`in_n` to `out_e`/`inst_e`/`out_s`.
- There is no combinational path from any input to any output.
- No backpressure. Upstream skews activations one cycle per row; the tile does not check the skew.

## Configuration
- `MAC_TILE_SAT_EN`:
  - Defined: the psum_bw+1-bit sum is clamped to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - Undefined: the sum wraps modulo 2^psum_bw, bit-identical to the existing `mac`.
- No port or latency difference between the two builds.

## Structure
- The shared package (include) holds:
  - Instruction bit indices: `INST_LOAD=0`, `INST_EXEC=1`.
  - The state encoding: EMPTY, LOADED.
  - The default widths.
- One sub-module is natural: the existing `mac`.
  - Instantiate it with `psum_bw+1` and a sign-extended `in_n`.
  - Apply the wrap or clamp in `mac_tile`.

## Test plan
- Reset: hold `reset` for 2 cycles with random inputs → `out_e=0`, `inst_e=0`, `out_s=0`; state EMPTY.
- Load chain: `inst_w=01` with `in_w=4'b1101`, then `inst_w=01` with `in_w=4'b0101`:
  - `b_q=-3`.
  - `out_e` is 1101 then 0101.
  - `inst_e` is 00 then 01.
- Execute with `b_q=-3`:
  - act=3, `in_n=10` → `out_s=1` next cycle.
  - act=2, `in_n=-5` → `out_s=-11`.
  - Then `inst_w=00` → `out_s` holds -11.
- Overflow with `b_q=7`, act=3, `in_n=32760`:
  - Without the macro → `out_s=-32755`.
  - With `MAC_TILE_SAT_EN` → `out_s=32767`.
  - Also `in_n=-32768`, `b_q=-8`, act=3 → wrap gives 32744; saturate gives -32768.
- Simultaneous load and execute in EMPTY: `inst_w=11`, `in_w=4'b0011`, `in_n=7` → `out_s=7` and `b_q=3`. Next cycle, `inst_w=10`, act=2, `in_n=0` → `out_s=6`.
- Reset mid-execute: assert `reset` during an execute stream → next cycle all outputs are 0 and the state is EMPTY. A following `inst_w=01` with `in_w=2` → `b_q=2`.

Source files
------------

// File: rtl/mac_tile_pkg.sv
// Shared definitions for the mac_tile processing element.
//   INST_LOAD / INST_EXEC : bit positions inside the 2-bit instruction bus
//   DEF_*_BW              : default widths for activation, weight and partial sum
//   tile_state_e          : weight-register occupancy (empty / loaded)
package mac_tile_pkg;

  localparam int unsigned INST_LOAD = 0;
  localparam int unsigned INST_EXEC = 1;

  localparam int unsigned DEF_A_BW    = 2;
  localparam int unsigned DEF_B_BW    = 4;
  localparam int unsigned DEF_PSUM_BW = 16;

  typedef enum logic {
    StEmpty  = 1'b0,
    StLoaded = 1'b1
  } tile_state_e;

endpackage

// File: rtl/mac_tile_mac.sv
// Combinational multiply-accumulate: o_out = i_c + zext(i_a) * i_b.
//   i_a   : unsigned activation, a_bw bits
//   i_b   : signed weight, b_bw bits
//   i_c   : signed addend, psum_bw bits
//   o_out : signed result, psum_bw bits, wraps modulo 2^psum_bw
module mac_tile_mac #(
  parameter int unsigned a_bw    = 2,
  parameter int unsigned b_bw    = 4,
  parameter int unsigned psum_bw = 17
) (
  input  logic        [a_bw-1:0]    i_a,
  input  logic signed [b_bw-1:0]    i_b,
  input  logic signed [psum_bw-1:0] i_c,
  output logic signed [psum_bw-1:0] o_out
);

  localparam int unsigned ProdBw = a_bw + b_bw + 1;

  logic signed [a_bw:0]     w_a_ext;
  logic signed [ProdBw-1:0] w_prod;

  // Extra zero MSB keeps the activation non-negative in the signed multiply.
  assign w_a_ext = $signed({1'b0, i_a});
  assign w_prod  = ProdBw'(w_a_ext) * ProdBw'(i_b);
  assign o_out   = i_c + psum_bw'(w_prod);

endmodule

// File: rtl/mac_tile.sv
// Weight-stationary systolic processing element.
// Latches one signed weight, forwards activations/instructions east and
// registered partial sums south. Every output is registered (1-cycle hop).
//   clk    : clock
//   reset  : synchronous active-high reset
//   in_w   : west bus (weight during load, activation in low a_bw bits on execute)
//   inst_w : instruction, bit0 = kernel load, bit1 = execute
//   in_n   : partial sum from the north
//   out_e  : registered forward of in_w (updates only when inst_w != 0)
//   inst_e : registered forward of inst_w (load bit masked while empty)
//   out_s  : registered partial sum to the south
// Build option: define MAC_TILE_SAT_EN to saturate the partial sum instead of wrapping.
module mac_tile
  import mac_tile_pkg::*;
#(
  parameter int unsigned a_bw    = DEF_A_BW,
  parameter int unsigned b_bw    = DEF_B_BW,
  parameter int unsigned psum_bw = DEF_PSUM_BW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [b_bw-1:0]    in_w,
  input  logic [1:0]         inst_w,
  input  logic [psum_bw-1:0] in_n,
  output logic [b_bw-1:0]    out_e,
  output logic [1:0]         inst_e,
  output logic [psum_bw-1:0] out_s
);

  tile_state_e r_state;
  tile_state_e w_state_d;

  logic signed [b_bw-1:0]  r_b_q;
  logic [b_bw-1:0]         r_out_e;
  logic [1:0]              r_inst_e;
  logic [psum_bw-1:0]      r_out_s;

  logic                    w_capture;
  logic                    w_fwd_load;
  logic signed [psum_bw:0] w_in_n_ext;
  logic signed [psum_bw:0] w_sum;
  logic [psum_bw-1:0]      w_sum_red;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next state: the first load moves to LOADED; only reset returns to EMPTY.
  always_comb begin
    w_state_d = r_state;
    if (r_state == StEmpty && inst_w[INST_LOAD]) begin
      w_state_d = StLoaded;
    end
  end

  // State-derived controls.
  always_comb begin
    w_capture  = (r_state == StEmpty) && inst_w[INST_LOAD];
    // The first weight is kept here; only later loads travel east.
    w_fwd_load = (r_state == StLoaded);
  end

  // One extra headroom bit so overflow is visible before reduction.
  assign w_in_n_ext = $signed({in_n[psum_bw-1], in_n});

  mac_tile_mac #(
    .a_bw   (a_bw),
    .b_bw   (b_bw),
    .psum_bw(psum_bw + 1)
  ) u_mac (
    .i_a  (in_w[a_bw-1:0]),
    .i_b  (r_b_q),
    .i_c  (w_in_n_ext),
    .o_out(w_sum)
  );

`ifdef MAC_TILE_SAT_EN
  localparam logic [psum_bw-1:0] PsumMax = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] PsumMin = {1'b1, {(psum_bw-1){1'b0}}};

  // Top two bits disagree exactly when the sum is outside the psum_bw range.
  always_comb begin
    w_sum_red = w_sum[psum_bw-1:0];
    if (w_sum[psum_bw] != w_sum[psum_bw-1]) begin
      w_sum_red = w_sum[psum_bw] ? PsumMin : PsumMax;
    end
  end
`else
  logic w_unused_sum_msb;
  assign w_unused_sum_msb = w_sum[psum_bw];
  assign w_sum_red        = w_sum[psum_bw-1:0];
`endif

  // Datapath registers. Execute reads the pre-capture weight on inst_w == 2'b11.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_b_q    <= '0;
      r_out_e  <= '0;
      r_inst_e <= '0;
      r_out_s  <= '0;
    end else begin
      if (w_capture) begin
        r_b_q <= $signed(in_w);
      end
      if (inst_w != 2'b00) begin
        r_out_e <= in_w;
      end
      r_inst_e[INST_EXEC] <= inst_w[INST_EXEC];
      r_inst_e[INST_LOAD] <= inst_w[INST_LOAD] & w_fwd_load;
      if (inst_w[INST_EXEC]) begin
        r_out_s <= w_sum_red;
      end
    end
  end

  assign out_e  = r_out_e;
  assign inst_e = r_inst_e;
  assign out_s  = r_out_s;

endmodule

// File: tb/tb_mac_tile.sv
module tb_mac_tile;
  import mac_tile_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  in_w;
  logic [1:0]  inst_w;
  logic [15:0] in_n;
  logic [3:0]  out_e;
  logic [1:0]  inst_e;
  logic [15:0] out_s;

  int total;
  int bad;

  // Reference model state, plain integers.
  int m_b;
  bit m_loaded;
  int m_out_e;
  int m_inst_e;
  int m_out_s;

  mac_tile dut (
    .clk   (clk),
    .reset (reset),
    .in_w  (in_w),
    .inst_w(inst_w),
    .in_n  (in_n),
    .out_e (out_e),
    .inst_e(inst_e),
    .out_s (out_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sext4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  function automatic int sext16(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic int reduce(input int s);
    logic signed [15:0] t;
`ifdef MAC_TILE_SAT_EN
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    t = s[15:0];
    return int'(t);
`endif
  endfunction

  // Apply one clock with the given inputs and advance the model.
  task automatic step(input bit rst, input int inst, input int inw, input int inn);
    int act;
    reset  = rst;
    inst_w = 2'(inst);
    in_w   = 4'(inw);
    in_n   = 16'(inn);
    @(posedge clk);
    if (rst) begin
      m_b = 0; m_loaded = 0; m_out_e = 0; m_inst_e = 0; m_out_s = 0;
    end else begin
      act = inw % 4;
      if (inst != 0) m_out_e = inw;
      m_inst_e = ((inst / 2) * 2) + ((inst % 2 == 1 && m_loaded) ? 1 : 0);
      if (inst / 2 == 1) m_out_s = reduce(sext16(inn) + act * m_b);
      if (inst % 2 == 1 && !m_loaded) begin
        m_b = sext4(inw);
        m_loaded = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 65535));
    step(1'b1, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 65535));
    total++; if (out_e !== 4'd0) begin bad++; $display("FAIL reset_out_e got=%h exp=0", out_e); end
    total++; if (inst_e !== 2'd0) begin bad++; $display("FAIL reset_inst_e got=%b exp=00", inst_e); end
    total++; if (out_s !== 16'd0) begin bad++; $display("FAIL reset_out_s got=%h exp=0", out_s); end
    total++; if (dut.r_state !== StEmpty) begin bad++; $display("FAIL reset_state got=%0d exp=EMPTY", dut.r_state); end
  endtask

  task automatic test_load_chain();
    step(1'b1, 0, 0, 0);
    step(1'b0, 1, 4'b1101, 0);
    total++; if (out_e !== 4'b1101) begin bad++; $display("FAIL load1_out_e got=%b exp=1101", out_e); end
    total++; if (inst_e !== 2'b00) begin bad++; $display("FAIL load1_inst_e got=%b exp=00", inst_e); end
    step(1'b0, 1, 4'b0101, 0);
    total++; if (out_e !== 4'b0101) begin bad++; $display("FAIL load2_out_e got=%b exp=0101", out_e); end
    total++; if (inst_e !== 2'b01) begin bad++; $display("FAIL load2_inst_e got=%b exp=01", inst_e); end
    total++; if (dut.r_b_q !== 4'b1101) begin bad++; $display("FAIL load_b_q got=%b exp=1101", dut.r_b_q); end
  endtask

  // Relies on b_q = -3 from test_load_chain.
  task automatic test_execute();
    step(1'b0, 2, 3, 10);
    total++; if (out_s !== 16'd1) begin bad++; $display("FAIL exec1_out_s got=%0d exp=1", $signed(out_s)); end
    total++; if (inst_e !== 2'b10) begin bad++; $display("FAIL exec1_inst_e got=%b exp=10", inst_e); end
    step(1'b0, 2, 2, -5 & 16'hffff);
    total++; if (out_s !== 16'hfff5) begin bad++; $display("FAIL exec2_out_s got=%0d exp=-11", $signed(out_s)); end
    step(1'b0, 0, 1, 100);
    total++; if (out_s !== 16'hfff5) begin bad++; $display("FAIL hold_out_s got=%0d exp=-11", $signed(out_s)); end
    total++; if (out_e !== 4'd2) begin bad++; $display("FAIL hold_out_e got=%h exp=2", out_e); end
  endtask

  task automatic test_overflow();
    logic [15:0] e1;
    logic [15:0] e2;
`ifdef MAC_TILE_SAT_EN
    e1 = 16'd32767;
    e2 = 16'h8000;
`else
    e1 = 16'h800d; // -32755
    e2 = 16'd32744;
`endif
    step(1'b1, 0, 0, 0);
    step(1'b0, 1, 7, 0);
    step(1'b0, 2, 3, 32760);
    total++; if (out_s !== e1) begin bad++; $display("FAIL ovf_pos got=%0d exp=%0d", $signed(out_s), $signed(e1)); end
    step(1'b1, 0, 0, 0);
    step(1'b0, 1, 4'b1000, 0);
    step(1'b0, 2, 3, 16'h8000);
    total++; if (out_s !== e2) begin bad++; $display("FAIL ovf_neg got=%0d exp=%0d", $signed(out_s), $signed(e2)); end
  endtask

  task automatic test_load_exec_same();
    step(1'b1, 0, 0, 0);
    step(1'b0, 3, 4'b0011, 7);
    total++; if (out_s !== 16'd7) begin bad++; $display("FAIL ldex_out_s got=%0d exp=7", $signed(out_s)); end
    total++; if (dut.r_b_q !== 4'd3) begin bad++; $display("FAIL ldex_b_q got=%0d exp=3", dut.r_b_q); end
    total++; if (inst_e !== 2'b10) begin bad++; $display("FAIL ldex_inst_e got=%b exp=10", inst_e); end
    step(1'b0, 2, 2, 0);
    total++; if (out_s !== 16'd6) begin bad++; $display("FAIL ldex_next_out_s got=%0d exp=6", $signed(out_s)); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 0, 0, 0);
    step(1'b0, 1, 5, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 2, $urandom_range(0, 15), $urandom_range(0, 65535));
    step(1'b1, 3, 4'hf, 1234);
    total++; if (out_e !== 4'd0 || inst_e !== 2'd0 || out_s !== 16'd0) begin
      bad++; $display("FAIL midrst_outs got=%h/%b/%h exp=0/00/0", out_e, inst_e, out_s);
    end
    total++; if (dut.r_state !== StEmpty) begin bad++; $display("FAIL midrst_state got=%0d exp=EMPTY", dut.r_state); end
    step(1'b0, 1, 2, 0);
    total++; if (dut.r_b_q !== 4'd2) begin bad++; $display("FAIL midrst_reload got=%0d exp=2", dut.r_b_q); end
  endtask

  task automatic test_random();
    step(1'b1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 40) == 0), $urandom_range(0, 3), $urandom_range(0, 15),
           $urandom_range(0, 65535));
      total++;
      if (out_e !== 4'(m_out_e) || inst_e !== 2'(m_inst_e) || out_s !== 16'(m_out_s)) begin
        bad++;
        $display("FAIL rand_%0d got=%h/%b/%h exp=%h/%b/%h", i, out_e, inst_e, out_s,
                 4'(m_out_e), 2'(m_inst_e), 16'(m_out_s));
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    m_b = 0; m_loaded = 0; m_out_e = 0; m_inst_e = 0; m_out_s = 0;
    reset = 1'b1; in_w = '0; inst_w = '0; in_n = '0;
    @(posedge clk); #1;
    test_reset();
    test_load_chain();
    test_execute();
    test_overflow();
    test_load_exec_same();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
